// File: rtl/regwb_pkg.sv
// Shared types for the register write-back path: producer requests, the
// register-file write port, and the special-register addresses it may target.
package regwb_pkg;

  localparam logic [7:0] RJ_ADDR = 8'd4;
  localparam logic [7:0] RP_ADDR = 8'd23;

  typedef struct packed {
    logic [1:0]  src;
    logic [7:0]  addr;
    logic [63:0] data;
  } wb_req;

  typedef struct packed {
    logic [1:0]  enable;
    logic [7:0]  addr;
    logic [63:0] data;
  } regwrite;

  // Only a single-bank select turns into a write; 00 and 11 are dropped.
  function automatic logic src_enqueues(input logic [1:0] src);
    return src[0] ^ src[1];
  endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Write-back FIFO with two ordered push ports (A before B), one pop port and
// a flat view of every slot plus its validity for the hazard lookup.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_a,
  input  wb_req                    din_a,
  input  logic                     push_b,
  input  wb_req                    din_b,
  input  logic                     pop,
  output wb_req                    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         entry_valid,
  output wb_req [DEPTH-1:0]        entries
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req [DEPTH-1:0] mem;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_b;

  // B lands behind A when both push in the same cycle.
  assign wr_ptr_b = wr_ptr + PW'(push_a);
  assign head     = mem[rd_ptr];
  assign entries  = mem;

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= din_a;
    if (push_b) mem[wr_ptr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = CW'(off) < count;
    end
  end

endmodule

// File: rtl/regwb.sv
// Register write-back unit: accepts load (A) and ALU (B) results, queues them,
// and issues at most one throttled regwrite per cycle with a hazard lookup.
module regwb
  import regwb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  wb_req      a_req,
  input  logic       b_valid,
  output logic       b_ready,
  input  wb_req      b_req,
  output regwrite    regw,
  input  logic [1:0] qry_src,
  input  logic [7:0] qry_addr,
  output logic       qry_hit,
  output logic       empty,
  output logic       err
);

  // valid/ready: a transfer happens on a posedge where valid & ready are both
  // high; ready depends only on the registered count (and a_valid for B), so
  // a pop in the same cycle never creates extra room until the next cycle.

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 2);

  logic [CW-1:0]     count;
  wb_req             head;
  logic [DEPTH-1:0]  entry_valid;
  wb_req [DEPTH-1:0] entries;
  logic [BW-1:0]     burst;
  logic              a_fire;
  logic              b_fire;
  logic              a_push;
  logic              b_push;
  logic              throttled;
  logic              pop;

  assign a_ready = count < CW'(DEPTH);
  assign b_ready = (count < CW'(DEPTH - 1)) | (a_ready & ~a_valid);
  assign a_fire  = a_valid & a_ready;
  assign b_fire  = b_valid & b_ready;
  assign a_push  = a_fire & src_enqueues(a_req.src);
  assign b_push  = b_fire & src_enqueues(b_req.src);

  // burst counts consecutive issued writes including the one now in regw.
  assign throttled = (MAX_BURST != 0) && (burst == BW'(MAX_BURST));
  assign pop       = (count != '0) && !throttled;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_a      (a_push),
    .din_a       (a_req),
    .push_b      (b_push),
    .din_b       (b_req),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regw  <= '0;
      burst <= '0;
      err   <= 1'b0;
    end else begin
      if (pop) begin
        regw.enable <= head.src;
        regw.addr   <= head.addr;
        regw.data   <= head.data;
        burst       <= (MAX_BURST == 0) ? '0 : burst + BW'(1);
      end else begin
        regw.enable <= '0;
        burst       <= '0;
      end
      if ((a_fire && a_req.src == 2'b11) || (b_fire && b_req.src == 2'b11))
        err <= 1'b1;
    end
  end

  assign empty = (count == '0) && (regw.enable == '0);

  // regw is included: the RAM still holds the old value during the write cycle.
  always_comb begin
    qry_hit = 1'b0;
    if (((regw.enable & qry_src) != '0) && (regw.addr == qry_addr))
      qry_hit = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && ((entries[i].src & qry_src) != '0) &&
          (entries[i].addr == qry_addr))
        qry_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_regwb.sv
// Directed bench for regwb (DEPTH=4, MAX_BURST=3); each task checks one scenario
// cycle by cycle against hand-derived expectations.
module tb_regwb;
  import regwb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid;
  logic       a_ready;
  wb_req      a_req;
  logic       b_valid;
  logic       b_ready;
  wb_req      b_req;
  regwrite    regw;
  logic [1:0] qry_src;
  logic [7:0] qry_addr;
  logic       qry_hit;
  logic       empty;
  logic       err;

  int checks = 0;
  int errors = 0;

  regwb #(.DEPTH(4), .MAX_BURST(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_req    (a_req),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_req    (b_req),
    .regw     (regw),
    .qry_src  (qry_src),
    .qry_addr (qry_addr),
    .qry_hit  (qry_hit),
    .empty    (empty),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_req   = '0;
    b_req   = '0;
  endtask

  task automatic set_a(input logic [1:0] src, input logic [7:0] addr, input logic [63:0] data);
    a_valid    = 1'b1;
    a_req.src  = src;
    a_req.addr = addr;
    a_req.data = data;
  endtask

  task automatic set_b(input logic [1:0] src, input logic [7:0] addr, input logic [63:0] data);
    b_valid    = 1'b1;
    b_req.src  = src;
    b_req.addr = addr;
    b_req.data = data;
  endtask

  task automatic test_reset;
    idle_inputs();
    qry_src  = 2'b11;
    qry_addr = 8'h00;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready, empty, qry_hit, err} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", {a_ready, b_ready, empty, qry_hit, err}, 5'b11100);
    end
    checks++;
    if (regw !== '0) begin
      errors++;
      $display("FAIL reset_regw got %h want 0", regw);
    end
    qry_src = 2'b00;
  endtask

  task automatic test_single;
    set_a(2'b01, 8'h20, 64'hDEAD);
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_a_ready got %b want 1", a_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (regw.enable !== 2'b00 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_c1 got en=%b empty=%b want en=00 empty=0", regw.enable, empty);
    end
    tick();
    checks++;
    if (regw !== {2'b01, 8'h20, 64'hDEAD}) begin
      errors++;
      $display("FAIL single_c2_regw got %h want %h", regw, {2'b01, 8'h20, 64'hDEAD});
    end
    tick();
    checks++;
    if (regw.enable !== 2'b00 || empty !== 1'b1 || regw.addr !== 8'h20) begin
      errors++;
      $display("FAIL single_c3 got en=%b empty=%b addr=%h want en=00 empty=1 addr=20",
               regw.enable, empty, regw.addr);
    end
  endtask

  task automatic test_dual;
    set_a(2'b10, 8'h05, 64'h5555);
    set_b(2'b10, 8'h06, 64'h6666);
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL dual_ready got %b want 11", {a_ready, b_ready});
    end
    tick();
    idle_inputs();
    tick();
    checks++;
    if (regw !== {2'b10, 8'h05, 64'h5555}) begin
      errors++;
      $display("FAIL dual_first got %h want %h", regw, {2'b10, 8'h05, 64'h5555});
    end
    tick();
    checks++;
    if (regw !== {2'b10, 8'h06, 64'h6666}) begin
      errors++;
      $display("FAIL dual_second got %h want %h", regw, {2'b10, 8'h06, 64'h6666});
    end
    tick();
    checks++;
    if (regw.enable !== 2'b00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL dual_drain got en=%b empty=%b want en=00 empty=1", regw.enable, empty);
    end
  endtask

  // 8 back-to-back A requests; 00 in the table marks an expected idle cycle.
  task automatic test_back_to_back;
    logic [7:0] exp_addr [13];
    exp_addr = '{8'h00, 8'h00, 8'h40, 8'h41, 8'h42, 8'h00, 8'h43,
                 8'h44, 8'h45, 8'h00, 8'h46, 8'h47, 8'h00};
    for (int c = 0; c < 13; c++) begin
      if (c < 8) set_a(2'b01, 8'h40 + 8'(c), {56'd0, 8'h40 + 8'(c)});
      else idle_inputs();
      #1;
      if (c < 8) begin
        checks++;
        if (a_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_a_ready c%0d got %b want 1", c, a_ready);
        end
      end
      checks++;
      if (exp_addr[c] == 8'h00) begin
        if (regw.enable !== 2'b00) begin
          errors++;
          $display("FAIL b2b_idle c%0d got en=%b want 00", c, regw.enable);
        end
      end else if (regw !== {2'b01, exp_addr[c], 56'd0, exp_addr[c]}) begin
        errors++;
        $display("FAIL b2b_write c%0d got %h want %h", c, regw, {2'b01, exp_addr[c], 56'd0, exp_addr[c]});
      end
      tick();
    end
  endtask

  // A and B both valid for 6 cycles; throttle stalls pops so the FIFO fills.
  task automatic test_full;
    logic [7:0] exp_addr [12];
    logic       exp_a [12];
    logic       exp_b [12];
    exp_addr = '{8'h00, 8'h00, 8'h60, 8'h70, 8'h61, 8'h00,
                 8'h71, 8'h62, 8'h63, 8'h00, 8'h64, 8'h00};
    exp_a    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_b    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        set_a(2'b01, 8'h60 + 8'(c), {56'd0, 8'h60 + 8'(c)});
        set_b(2'b01, 8'h70 + 8'(c), {56'd0, 8'h70 + 8'(c)});
      end else begin
        idle_inputs();
      end
      #1;
      checks++;
      if ({a_ready, b_ready} !== {exp_a[c], exp_b[c]}) begin
        errors++;
        $display("FAIL full_ready c%0d got %b want %b", c, {a_ready, b_ready}, {exp_a[c], exp_b[c]});
      end
      checks++;
      if (exp_addr[c] == 8'h00) begin
        if (regw.enable !== 2'b00) begin
          errors++;
          $display("FAIL full_idle c%0d got en=%b want 00", c, regw.enable);
        end
      end else if (regw !== {2'b01, exp_addr[c], 56'd0, exp_addr[c]}) begin
        errors++;
        $display("FAIL full_write c%0d got %h want %h", c, regw, {2'b01, exp_addr[c], 56'd0, exp_addr[c]});
      end
      tick();
    end
  endtask

  task automatic test_hazard;
    qry_src  = 2'b01;
    qry_addr = 8'h10;
    set_a(2'b01, 8'h10, 64'h1010);
    #1;
    checks++;
    if (qry_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_before got %b want 0", qry_hit);
    end
    tick();
    idle_inputs();
    checks++;
    if (qry_hit !== 1'b1) begin
      errors++;
      $display("FAIL hazard_queued got %b want 1", qry_hit);
    end
    qry_src = 2'b10;
    #1;
    checks++;
    if (qry_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_other_bank got %b want 0", qry_hit);
    end
    qry_src = 2'b00;
    #1;
    checks++;
    if (qry_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_src0 got %b want 0", qry_hit);
    end
    qry_src = 2'b11;
    #1;
    checks++;
    if (qry_hit !== 1'b1) begin
      errors++;
      $display("FAIL hazard_both_banks got %b want 1", qry_hit);
    end
    qry_src  = 2'b01;
    qry_addr = 8'h11;
    #1;
    checks++;
    if (qry_hit !== 1'b0) begin
      errors++;
      $display("FAIL hazard_other_addr got %b want 0", qry_hit);
    end
    qry_addr = 8'h10;
    tick();
    checks++;
    if (qry_hit !== 1'b1 || regw.enable !== 2'b01) begin
      errors++;
      $display("FAIL hazard_in_regw got hit=%b en=%b want hit=1 en=01", qry_hit, regw.enable);
    end
    tick();
    checks++;
    if (qry_hit !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL hazard_after got hit=%b empty=%b want hit=0 empty=1", qry_hit, empty);
    end
    qry_src = 2'b00;
  endtask

  task automatic test_err;
    set_a(2'b11, 8'h33, 64'h3333);
    #1;
    checks++;
    if (a_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_pre got ready=%b err=%b want ready=1 err=0", a_ready, err);
    end
    tick();
    idle_inputs();
    set_b(2'b00, 8'h34, 64'h3434);
    checks++;
    if (err !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL err_set got err=%b empty=%b want err=1 empty=1", err, empty);
    end
    tick();
    idle_inputs();
    tick();
    checks++;
    if (err !== 1'b1 || regw.enable !== 2'b00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got err=%b en=%b empty=%b want err=1 en=00 empty=1",
               err, regw.enable, empty);
    end
  endtask

  task automatic test_reset_mid;
    set_a(2'b01, 8'h80, 64'h80);
    set_b(2'b01, 8'h90, 64'h90);
    tick();
    set_a(2'b01, 8'h81, 64'h81);
    set_b(2'b01, 8'h91, 64'h91);
    tick();
    idle_inputs();
    reset_n = 1'b0;
    checks++;
    if (regw !== {2'b01, 8'h80, 64'h80} || err !== 1'b1) begin
      errors++;
      $display("FAIL mid_inflight got regw=%h err=%b want regw=%h err=1", regw, err, {2'b01, 8'h80, 64'h80});
    end
    tick();
    reset_n = 1'b1;
    checks++;
    if (regw !== '0 || empty !== 1'b1 || err !== 1'b0 || {a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset got regw=%h empty=%b err=%b ready=%b want 0/1/0/11",
               regw, empty, err, {a_ready, b_ready});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (regw.enable !== 2'b00 || empty !== 1'b1) begin
        errors++;
        $display("FAIL mid_quiet c%0d got en=%b empty=%b want en=00 empty=1", c, regw.enable, empty);
      end
    end
  endtask

  initial begin
    idle_inputs();
    qry_src  = 2'b00;
    qry_addr = 8'h00;
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_full();
    test_hazard();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
